// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch definitions: condition codes, flag bit positions, predictor
// counter reset value and the condition evaluator used by EX and the decoder.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    COND_EQ = 3'b000,
    COND_NE = 3'b001,
    COND_LT = 3'b010,
    COND_GE = 3'b011,
    COND_CS = 3'b100,
    COND_CC = 3'b101,
    COND_AL = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] PHT_INIT = 2'b01;

  function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] f);
    logic res;
    res = 1'b0;
    case (cond_e'(cond))
      COND_EQ: res = f[FLAG_Z];
      COND_NE: res = !f[FLAG_Z];
      COND_LT: res = f[FLAG_N] ^ f[FLAG_V];
      COND_GE: res = !(f[FLAG_N] ^ f[FLAG_V]);
      COND_CS: res = f[FLAG_C];
      COND_CC: res = !f[FLAG_C];
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pht.sv
// Pattern history table of 2-bit saturating counters with one combinational
// read port and one registered, saturating update port.
module branch_pht
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDXW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_taken,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic            wr_taken
);

  logic [1:0] pht_q [DEPTH];
  logic [1:0] pht_d [DEPTH];

  // Read sees the pre-update value; a same-cycle write lands at the edge.
  assign rd_taken = pht_q[rd_idx][1];

  always_comb begin
    pht_d = pht_q;
    if (wr_en) begin
      if (wr_taken) begin
        if (pht_q[wr_idx] != 2'b11) pht_d[wr_idx] = pht_q[wr_idx] + 2'd1;
      end else begin
        if (pht_q[wr_idx] != 2'b00) pht_d[wr_idx] = pht_q[wr_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pht_q[i] <= PHT_INIT;
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: registered ZNCV flag file with same-cycle bypass, 8-way
// condition evaluation, PHT-based prediction and registered mispredict report.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned PHT_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flag_we,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_carry,
  input  logic                alu_ovf,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                pred_taken,
  input  logic                br_valid,
  input  logic [2:0]          br_cond,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic                br_pred,
  output logic                br_done,
  output logic                br_taken,
  output logic                br_mispredict,
  output logic [3:0]          flags
);

  localparam int unsigned IDX = $clog2(PHT_DEPTH);

  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_flags, eval_flags;
  logic       br_done_q, br_done_d;
  logic       br_taken_q, br_taken_d;
  logic       br_mispredict_q, br_mispredict_d;
  logic       cond_taken;

  // Only the index bits of each PC feed the table; the rest is deliberately dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc, br_pc};

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_result == '0);
    alu_flags[FLAG_N] = alu_result[WIDTH-1];
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_V] = alu_ovf;

    eval_flags = flag_we ? alu_flags : flags_q;
    cond_taken = cond_eval(br_cond, eval_flags);

    flags_d         = flag_we ? alu_flags : flags_q;
    br_done_d       = br_valid;
    br_taken_d      = br_valid ? cond_taken : br_taken_q;
    br_mispredict_d = br_valid ? (cond_taken ^ br_pred) : br_mispredict_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q         <= '0;
      br_done_q       <= 1'b0;
      br_taken_q      <= 1'b0;
      br_mispredict_q <= 1'b0;
    end else begin
      flags_q         <= flags_d;
      br_done_q       <= br_done_d;
      br_taken_q      <= br_taken_d;
      br_mispredict_q <= br_mispredict_d;
    end
  end

  branch_pht #(
    .DEPTH (PHT_DEPTH),
    .IDXW  (IDX)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (fetch_pc[IDX+1:2]),
    .rd_taken (pred_taken),
    .wr_en    (br_valid),
    .wr_idx   (br_pc[IDX+1:2]),
    .wr_taken (cond_taken)
  );

  assign flags         = flags_q;
  assign br_done       = br_done_q;
  assign br_taken      = br_taken_q;
  assign br_mispredict = br_mispredict_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a behavioural
// model of the flag file, condition table and saturating predictor counters.
module tb_branch_resolve_unit;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned PC_WIDTH  = 32;
  localparam int unsigned PHT_DEPTH = 16;

  logic                clk;
  logic                rst_n;
  logic                flag_we;
  logic [WIDTH-1:0]    alu_result;
  logic                alu_carry;
  logic                alu_ovf;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                pred_taken;
  logic                br_valid;
  logic [2:0]          br_cond;
  logic [PC_WIDTH-1:0] br_pc;
  logic                br_pred;
  logic                br_done;
  logic                br_taken;
  logic                br_mispredict;
  logic [3:0]          flags;

  branch_resolve_unit #(
    .WIDTH     (WIDTH),
    .PC_WIDTH  (PC_WIDTH),
    .PHT_DEPTH (PHT_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flag_we       (flag_we),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_ovf       (alu_ovf),
    .fetch_pc      (fetch_pc),
    .pred_taken    (pred_taken),
    .br_valid      (br_valid),
    .br_cond       (br_cond),
    .br_pc         (br_pc),
    .br_pred       (br_pred),
    .br_done       (br_done),
    .br_taken      (br_taken),
    .br_mispredict (br_mispredict),
    .flags         (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: counters as plain integers, flags as four bits.
  int m_pht [PHT_DEPTH];
  int m_z, m_n, m_c, m_v;
  int e_done, e_taken, e_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % PHT_DEPTH);
  endfunction

  function automatic int model_cond(input int cond, input int z, input int n, input int c, input int v);
    case (cond)
      0: return z;
      1: return (z == 0) ? 1 : 0;
      2: return (n != v) ? 1 : 0;
      3: return (n == v) ? 1 : 0;
      4: return c;
      5: return (c == 0) ? 1 : 0;
      6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PHT_DEPTH; i++) m_pht[i] = 1;
    m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    e_done = 0; e_taken = 0; e_mis = 0;
  endtask

  // One clock: drive after the falling edge, check prediction before the
  // rising edge, then check registered outputs just after it.
  task automatic cycle(input logic fwe, input logic [31:0] res, input logic car,
                       input logic ovf, input logic [31:0] fpc, input logic bv,
                       input logic [2:0] cond, input logic [31:0] bpc, input logic bp);
    int z, n, c, v, t, k;
    @(negedge clk);
    flag_we = fwe; alu_result = res; alu_carry = car; alu_ovf = ovf;
    fetch_pc = fpc; br_valid = bv; br_cond = cond; br_pc = bpc; br_pred = bp;
    #1;
    check("pred_taken", {31'd0, pred_taken}, (m_pht[pc_idx(fpc)] >= 2) ? 32'd1 : 32'd0);
    if (fwe) begin
      z = (res == 0) ? 1 : 0; n = int'(res[31]); c = int'(car); v = int'(ovf);
    end else begin
      z = m_z; n = m_n; c = m_c; v = m_v;
    end
    e_done = bv ? 1 : 0;
    if (bv) begin
      t = model_cond(int'(cond), z, n, c, v);
      e_taken = t;
      e_mis = (t != int'(bp)) ? 1 : 0;
      k = pc_idx(bpc);
      if (t == 1) m_pht[k] = (m_pht[k] < 3) ? m_pht[k] + 1 : 3;
      else        m_pht[k] = (m_pht[k] > 0) ? m_pht[k] - 1 : 0;
    end
    if (fwe) begin
      m_z = z; m_n = n; m_c = c; m_v = v;
    end
    @(posedge clk);
    #1;
    check("br_done", {31'd0, br_done}, e_done);
    check("br_taken", {31'd0, br_taken}, e_taken);
    check("br_mispredict", {31'd0, br_mispredict}, e_mis);
    check("flags", {28'd0, flags}, (m_z * 8) + (m_n * 4) + (m_c * 2) + m_v);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic reset_midstream();
    logic [31:0] fpc;
    @(negedge clk);
    flag_we = 1'b1; alu_result = 32'h8000_0000; alu_carry = 1'b1; alu_ovf = 1'b1;
    br_valid = 1'b1; br_cond = 3'd6; br_pc = 32'h40; br_pred = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_done", {31'd0, br_done}, 32'd0);
    for (int i = 0; i < PHT_DEPTH; i++) begin
      fpc = i * 4;
      fetch_pc = fpc;
      #0.1;
      check("rst_pred", {31'd0, pred_taken}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("rst_hold_done", {31'd0, br_done}, 32'd0);
    check("rst_hold_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    flag_we = 1'b0; br_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    flag_we = 1'b0; alu_result = '0; alu_carry = 1'b0; alu_ovf = 1'b0;
    fetch_pc = '0; br_valid = 1'b0; br_cond = '0; br_pc = '0; br_pred = 1'b0;
    model_reset();
    #3;
    check("init_flags", {28'd0, flags}, 32'd0);
    check("init_done", {31'd0, br_done}, 32'd0);
    check("init_pred", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Condition sweep over four flag settings.
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
        1: cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
        2: cycle(1'b1, 32'h5, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
        default: cycle(1'b1, 32'h5, 1'b0, 1'b1, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      endcase
      for (int cnd = 0; cnd < 8; cnd++)
        cycle(1'b0, 32'h1, 1'b0, 1'b0, $urandom, 1'b1, 3'(cnd), $urandom, 1'($urandom));
    end

    // Bypass: Z=0 in the register, Z=1 arriving with the branch.
    cycle(1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 32'h100, 1'b0);
    check("bypass_taken", {31'd0, br_taken}, 32'd1);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 32'h100, 1'b0);
    check("reg_taken", {31'd0, br_taken}, 32'd1);

    // Saturation on 0x40 from a clean table.
    reset_midstream();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h40, 1'b1, 3'd6, 32'h40, 1'b0);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h40, 1'b0, 3'd0, 32'h0, 1'b0);
    check("sat_hi_pred", {31'd0, pred_taken}, 32'd1);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h40, 1'b1, 3'd7, 32'h40, 1'b1);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h40, 1'b1, 3'd6, 32'h40, 1'b0);
    check("sat_lo_pred", {31'd0, pred_taken}, 32'd0);

    // Collision: write index 1 via 0x04 while fetching 0x44.
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h44, 1'b1, 3'd6, 32'h04, 1'b0);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h44, 1'b0, 3'd0, 32'h0, 1'b0);

    // Mispredict cases.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 32'h80, 1'b1);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd6, 32'h80, 1'b0);
    cycle(1'b0, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd7, 32'h80, 1'b0);
    idle();

    // Random traffic with a narrow PC range so indices collide often.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
            1'($urandom), 1'($urandom),
            32'($urandom_range(0, 127)),
            1'($urandom_range(0, 3) != 0),
            3'($urandom),
            32'($urandom_range(0, 127)),
            1'($urandom));
      if (i == 200) reset_midstream();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
